// File: rtl/mcpu_pkg.sv
// mcpu_pkg
// Shared encodings for the multi-cycle MIPS-subset controller: FSM state
// numbers, instruction opcode/funct fields, ALU operation codes and the
// datapath mux select values driven by the controller.
package mcpu_pkg;

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_MA  = 4'd2,
        S_MR  = 4'd3,
        S_MWB = 4'd4,
        S_MW  = 4'd5,
        S_EXR = 4'd6,
        S_RWB = 4'd7,
        S_BR  = 4'd8,
        S_JMP = 4'd9,
        S_EXI = 4'd10,
        S_IWB = 4'd11,
        S_JAL = 4'd12,
        S_ILL = 4'd13
    } state_t;

    // opcode field IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // funct field IR[5:0] for R-type
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes; 3'd5 is unused and never driven
    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SLL = 3'd3;
    localparam logic [2:0] ALU_SRL = 3'd4;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    // register file write address select
    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    // register file write data select
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    // ALU A operand select
    localparam logic [1:0] SRCA_PC = 2'd0;
    localparam logic [1:0] SRCA_RS = 2'd1;
    localparam logic [1:0] SRCA_RT = 2'd2;

    // ALU B operand select
    localparam logic [1:0] SRCB_BREG   = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // next-PC select
    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;

endpackage

// File: rtl/mcpu_alu_dec.sv
// mcpu_alu_dec
// Combinational ALU decoder shared by the R-type and immediate execute
// states. For R-type the funct field picks the operation; otherwise the
// opcode does (addi/andi/ori/slti only).
// Ports:
//   opcode    in  6  instruction opcode
//   funct     in  6  instruction funct (R-type only)
//   alu_op    out 3  ALU operation code
//   shift_sel out 1  operation is sll/srl (A = rt, B = imm for shamt)
//   legal     out 1  opcode/funct combination is supported
module mcpu_alu_dec
    import mcpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       shift_sel,
    output logic       legal
);

    always_comb begin
        alu_op    = ALU_ADD;
        shift_sel = 1'b0;
        legal     = 1'b0;
        if (opcode == OP_RTYPE) begin
            legal = 1'b1;
            case (funct)
                FN_ADD:  alu_op = ALU_ADD;
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                FN_SLL: begin
                    alu_op    = ALU_SLL;
                    shift_sel = 1'b1;
                end
                FN_SRL: begin
                    alu_op    = ALU_SRL;
                    shift_sel = 1'b1;
                end
                default: legal = 1'b0;
            endcase
        end else begin
            legal = 1'b1;
            case (opcode)
                OP_ADDI: alu_op = ALU_ADD;
                OP_ANDI: alu_op = ALU_AND;
                OP_ORI:  alu_op = ALU_OR;
                OP_SLTI: alu_op = ALU_SLT;
                default: legal  = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl
// Multi-cycle control FSM for the MIPS-subset CPU. Sequences the shared
// ALU/shifter datapath and the unified memory through fetch, decode,
// execute, memory and writeback. Outputs are decoded from the state
// register; mem_ready inserts wait states in IF, MR and MW.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   opcode, funct       instruction fields (stable from ID onward)
//   zero                ALU zero flag, same cycle (branch resolve)
//   mem_ready           memory finishes the current access this cycle
//   pc_we, iord, mem_rd, mem_wr, ir_we     PC / memory / IR controls
//   reg_dst, mem2reg, reg_we               register file write controls
//   alu_src_a, alu_src_b, alu_op, pc_src   datapath mux selects / ALU op
//   illegal             one-cycle pulse on an undecodable instruction
//   state               current state, for debug
//
// state | meaning
// ------+----------------------------------------------------------
// IF  0 | fetch: read mem[PC], PC += 4, load IR when mem_ready
// ID  1 | decode: ALUOut = PC + (imm << 2) as branch target
// MA  2 | address: ALUOut = rs + imm
// MR  3 | load read, waits for mem_ready
// MWB 4 | load writeback: rt = MDR
// MW  5 | store write, waits for mem_ready
// EXR 6 | R-type execute (funct selects op, shifts use rt/shamt)
// RWB 7 | R-type writeback: rd = ALUOut
// BR  8 | beq/bne compare; PC = ALUOut when taken
// JMP 9 | j: PC = jump target
// EXI 10| I-type execute: rs op imm
// IWB 11| I-type writeback: rt = ALUOut
// JAL 12| jal: $31 = PC (already +4), PC = jump target
// ILL 13| undecodable instruction; pulse illegal
module mcpu_ctrl
    import mcpu_pkg::*;
#(
    parameter logic [3:0] RESET_STATE  = 4'd0,
    parameter bit         ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_we,
    output logic [1:0] reg_dst,
    output logic [1:0] mem2reg,
    output logic       reg_we,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic       ill_seen_q;
    logic       mem_rdy;
    logic [2:0] dec_op;
    logic       dec_shift;
    logic       dec_legal;

    mcpu_alu_dec u_alu_dec (
        .opcode    (opcode),
        .funct     (funct),
        .alu_op    (dec_op),
        .shift_sel (dec_shift),
        .legal     (dec_legal)
    );

    // While reset is held the FSM shows its reset state, but no memory
    // access may be considered complete, so every enable stays low.
    assign mem_rdy = mem_ready & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= state_t'(RESET_STATE);
            ill_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // remembers that ILL was already occupied last cycle, so a
            // trapped controller pulses illegal only once
            ill_seen_q <= (state_q == S_ILL);
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_we     = 1'b0;
        iord      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        ir_we     = 1'b0;
        reg_dst   = DST_RT;
        mem2reg   = M2R_ALUOUT;
        reg_we    = 1'b0;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_BREG;
        alu_op    = ALU_AND;
        pc_src    = PCS_ALU;
        illegal   = 1'b0;

        case (state_q)
            S_IF: begin
                mem_rd    = 1'b1;
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                pc_src    = PCS_ALU;
                if (mem_rdy) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:                      state_d = S_MA;
                    OP_RTYPE:                          state_d = S_EXR;
                    OP_BEQ, OP_BNE:                    state_d = S_BR;
                    OP_J:                              state_d = S_JMP;
                    OP_JAL:                            state_d = S_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXI;
                    default:                           state_d = S_ILL;
                endcase
            end
            S_MA: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                state_d   = (opcode == OP_SW) ? S_MW : S_MR;
            end
            S_MR: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                if (mem_rdy) begin
                    state_d = S_MWB;
                end
            end
            S_MWB: begin
                reg_dst = DST_RT;
                mem2reg = M2R_MDR;
                reg_we  = 1'b1;
                state_d = S_IF;
            end
            S_MW: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                if (mem_rdy) begin
                    state_d = S_IF;
                end
            end
            S_EXR: begin
                alu_op = dec_op;
                // shamt lives in imm[10:6], so shifts take rt on A and the
                // sign-extended immediate on B
                if (dec_shift) begin
                    alu_src_a = SRCA_RT;
                    alu_src_b = SRCB_IMM;
                end else begin
                    alu_src_a = SRCA_RS;
                    alu_src_b = SRCB_BREG;
                end
                state_d = dec_legal ? S_RWB : S_ILL;
            end
            S_RWB: begin
                reg_dst = DST_RD;
                mem2reg = M2R_ALUOUT;
                reg_we  = 1'b1;
                state_d = S_IF;
            end
            S_BR: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_BREG;
                alu_op    = ALU_SUB;
                pc_src    = PCS_ALUOUT;
                pc_we     = (opcode == OP_BNE) ? ~zero : zero;
                state_d   = S_IF;
            end
            S_JMP: begin
                pc_src  = PCS_JUMP;
                pc_we   = 1'b1;
                state_d = S_IF;
            end
            S_JAL: begin
                reg_dst = DST_RA;
                mem2reg = M2R_PC;
                reg_we  = 1'b1;
                pc_src  = PCS_JUMP;
                pc_we   = 1'b1;
                state_d = S_IF;
            end
            S_EXI: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_IMM;
                alu_op    = dec_op;
                state_d   = dec_legal ? S_IWB : S_ILL;
            end
            S_IWB: begin
                reg_dst = DST_RT;
                mem2reg = M2R_ALUOUT;
                reg_we  = 1'b1;
                state_d = S_IF;
            end
            S_ILL: begin
                illegal = ~ill_seen_q;
                state_d = ILLEGAL_TRAP ? S_ILL : S_IF;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mcpu_ctrl.sv
module tb_mcpu_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_we, iord, mem_rd, mem_wr, ir_we, reg_we, illegal;
    logic [1:0] reg_dst, mem2reg, alu_src_a, alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;

    mcpu_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_we     (pc_we),
        .iord      (iord),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .ir_we     (ir_we),
        .reg_dst   (reg_dst),
        .mem2reg   (mem2reg),
        .reg_we    (reg_we),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .pc_src    (pc_src),
        .illegal   (illegal),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // {state, pc_we, iord, mem_rd, mem_wr, ir_we, reg_dst, mem2reg, reg_we,
    //  alu_src_a, alu_src_b, alu_op, pc_src, illegal}
    logic [23:0] act;
    assign act = {state, pc_we, iord, mem_rd, mem_wr, ir_we, reg_dst, mem2reg,
                  reg_we, alu_src_a, alu_src_b, alu_op, pc_src, illegal};

    function automatic logic [23:0] mk(input int st, input int pcwe, input int io,
                                       input int rd, input int wr, input int irwe,
                                       input int rdst, input int m2r, input int rwe,
                                       input int a, input int b, input int op,
                                       input int pcs, input int ill);
        logic [3:0] s4;
        logic [1:0] d2, m2, a2, b2, p2;
        logic [2:0] o3;
        s4 = st[3:0]; d2 = rdst[1:0]; m2 = m2r[1:0]; a2 = a[1:0];
        b2 = b[1:0];  p2 = pcs[1:0];  o3 = op[2:0];
        return {s4, pcwe[0], io[0], rd[0], wr[0], irwe[0], d2, m2, rwe[0],
                a2, b2, o3, p2, ill[0]};
    endfunction

    //                               st pw io rd wr ir dst m2r we  a  b op pcs ill
    logic [23:0] V_IF_NR, V_IF_R, V_ID, V_MA, V_MR, V_MWB, V_MW, V_SLL, V_SRL,
                 V_SUB, V_SLT, V_RWB, V_ORI, V_IWB, V_BR_T, V_BR_N, V_JMP,
                 V_JAL, V_ILL;

    initial begin
        V_IF_NR = mk( 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        V_IF_R  = mk( 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 2, 0, 0);
        V_ID    = mk( 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0);
        V_MA    = mk( 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0);
        V_MR    = mk( 3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        V_MWB   = mk( 4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        V_MW    = mk( 5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        V_SLL   = mk( 6, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 3, 0, 0);
        V_SRL   = mk( 6, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 4, 0, 0);
        V_SUB   = mk( 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6, 0, 0);
        V_SLT   = mk( 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0);
        V_RWB   = mk( 7, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        V_ORI   = mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0);
        V_IWB   = mk(11, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        V_BR_T  = mk( 8, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6, 1, 0);
        V_BR_N  = mk( 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6, 1, 0);
        V_JMP   = mk( 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        V_JAL   = mk(12, 1, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0, 2, 0);
        V_ILL   = mk(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    end

    // monitor: the controller presents a full output word every cycle;
    // compare mid-cycle against the oldest pending expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %06h (state %0d) expected %06h (state %0d) at %0t",
                         e.name, act, act[23:20], e.v, e.v[23:20], $time);
            end
        end
    end

    // called just after a rising edge: drive this cycle's inputs, queue
    // the expected outputs, advance one cycle
    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input logic [23:0] v,
                        input string name);
        exp_t e;
        rst       = r;
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = rdy;
        e.v       = v;
        e.name    = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_dec(input logic [5:0] op, input logic [5:0] fn, input string nm);
        step(0, op, fn, 0, 1, V_IF_R, {nm, "_if"});
        step(0, op, fn, 0, 1, V_ID,   {nm, "_id"});
    endtask

    initial begin
        rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        // reset: IF decode with enables suppressed although mem_ready=1
        step(1, 6'h23, 6'h00, 0, 1, V_IF_NR, "reset_if");
        step(1, 6'h23, 6'h00, 0, 1, V_IF_NR, "reset_if2");

        // lw, zero wait states: 0,1,2,3,4,0
        fetch_dec(6'h23, 6'h00, "lw");
        step(0, 6'h23, 6'h00, 0, 1, V_MA,  "lw_ma");
        step(0, 6'h23, 6'h00, 0, 1, V_MR,  "lw_mr");
        step(0, 6'h23, 6'h00, 0, 1, V_MWB, "lw_mwb");

        // sw with three wait states in MW
        fetch_dec(6'h2B, 6'h00, "sw");
        step(0, 6'h2B, 6'h00, 0, 1, V_MA, "sw_ma");
        step(0, 6'h2B, 6'h00, 0, 0, V_MW, "sw_mw_wait1");
        step(0, 6'h2B, 6'h00, 0, 0, V_MW, "sw_mw_wait2");
        step(0, 6'h2B, 6'h00, 0, 0, V_MW, "sw_mw_wait3");
        step(0, 6'h2B, 6'h00, 0, 1, V_MW, "sw_mw_done");

        // R-type sll / srl / sub / slt
        fetch_dec(6'h00, 6'h00, "sll");
        step(0, 6'h00, 6'h00, 0, 1, V_SLL, "sll_exr");
        step(0, 6'h00, 6'h00, 0, 1, V_RWB, "sll_rwb");
        fetch_dec(6'h00, 6'h02, "srl");
        step(0, 6'h00, 6'h02, 0, 1, V_SRL, "srl_exr");
        step(0, 6'h00, 6'h02, 0, 1, V_RWB, "srl_rwb");
        fetch_dec(6'h00, 6'h22, "sub");
        step(0, 6'h00, 6'h22, 0, 1, V_SUB, "sub_exr");
        step(0, 6'h00, 6'h22, 0, 1, V_RWB, "sub_rwb");
        fetch_dec(6'h00, 6'h2A, "slt");
        step(0, 6'h00, 6'h2A, 0, 1, V_SLT, "slt_exr");
        step(0, 6'h00, 6'h2A, 0, 1, V_RWB, "slt_rwb");

        // ori
        fetch_dec(6'h0D, 6'h00, "ori");
        step(0, 6'h0D, 6'h00, 0, 1, V_ORI, "ori_exi");
        step(0, 6'h0D, 6'h00, 0, 1, V_IWB, "ori_iwb");

        // beq taken, bne not taken with zero=1
        fetch_dec(6'h04, 6'h00, "beq");
        step(0, 6'h04, 6'h00, 1, 1, V_BR_T, "beq_br_z1");
        fetch_dec(6'h05, 6'h00, "bne");
        step(0, 6'h05, 6'h00, 1, 1, V_BR_N, "bne_br_z1");

        // j, jal
        fetch_dec(6'h02, 6'h00, "j");
        step(0, 6'h02, 6'h00, 0, 1, V_JMP, "j_jmp");
        fetch_dec(6'h03, 6'h00, "jal");
        step(0, 6'h03, 6'h00, 0, 1, V_JAL, "jal_jal");

        // undecodable opcode: one-cycle illegal pulse, then IF
        fetch_dec(6'h3F, 6'h00, "ill");
        step(0, 6'h3F, 6'h00, 0, 1, V_ILL,  "ill_pulse");
        step(0, 6'h3F, 6'h00, 0, 0, V_IF_NR, "ill_back_if");

        // reset asserted mid-read: state drops to IF before the next edge
        step(0, 6'h23, 6'h00, 0, 1, V_IF_R, "abort_if");
        step(0, 6'h23, 6'h00, 0, 1, V_ID,   "abort_id");
        step(0, 6'h23, 6'h00, 0, 1, V_MA,   "abort_ma");
        step(0, 6'h23, 6'h00, 0, 0, V_MR,   "abort_mr_wait");
        step(1, 6'h23, 6'h00, 0, 1, V_IF_NR, "abort_async_if");
        step(1, 6'h23, 6'h00, 0, 1, V_IF_NR, "abort_hold_if");
        step(0, 6'h23, 6'h00, 0, 1, V_IF_R, "after_reset_if");
        step(0, 6'h23, 6'h00, 0, 1, V_ID,   "after_reset_id");

        // drain: every queued expectation must have been consumed
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
